// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl
//   Issue controller between the ID-stage decoder and the register file.
//   It keeps a small outstanding-write counter for each architectural
//   register (r1..r31), stalls ID on RAW hazards or counter saturation,
//   and sequences the 1-cycle synchronous register file read.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_id_valid            ID holds a decoded instruction
//   i_id_rs, i_id_rt      source registers (rt only counts when i_id_uses_rt)
//   i_id_dest_en/i_id_dest destination write enable / register
//   i_wb_en, i_wb_rd      writeback retires one write to i_wb_rd
//   o_stall, o_issue      combinational hold / issue for this cycle
//   o_opnd_valid          regfile read data valid (cycle after issue)
//   o_opnd_rs, o_opnd_rt  source registers of the issued instruction
//   o_pending_mask        bit i set while register i has outstanding writes
//   o_stall_cycles        saturating count of stalled cycles
//   o_wb_underflow        sticky: writeback retired with nothing outstanding
module reg_scoreboard_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic                   i_id_dest_en,
  input  logic [4:0]             i_id_dest,
  input  logic                   i_wb_en,
  input  logic [4:0]             i_wb_rd,
  output logic                   o_stall,
  output logic                   o_issue,
  output logic                   o_opnd_valid,
  output logic [4:0]             o_opnd_rs,
  output logic [4:0]             o_opnd_rt,
  output logic [31:0]            o_pending_mask,
  output logic [STALL_CNT_W-1:0] o_stall_cycles,
  output logic                   o_wb_underflow
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0]          r_cnt [1:31];
  logic                   r_opnd_valid;
  logic [4:0]             r_opnd_rs;
  logic [4:0]             r_opnd_rt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   r_wb_underflow;

  // w_cnt extends the counters with a constant-zero entry for r0 so every
  // 5-bit register number can index it directly.
  logic [CW-1:0] w_cnt [32];
  logic [31:1]   w_pend;
  logic [31:1]   w_inc;
  logic [31:1]   w_dec;
  logic          w_raw_rs;
  logic          w_raw_rt;
  logic          w_sat;
  logic          w_stall;
  logic          w_issue;
  logic          w_underflow;

  always_comb begin
    w_cnt[0] = '0;
    w_pend   = '0;
    for (int i = 1; i < 32; i++) begin
      w_cnt[i]  = r_cnt[i];
      w_pend[i] = (r_cnt[i] != '0);
    end
  end

  // Hazards use pre-issue counts, so a self-dependent instruction
  // (rs == dest) only sees writes issued before it.
  assign w_raw_rs = (w_cnt[i_id_rs] != '0);
  assign w_raw_rt = i_id_uses_rt && (w_cnt[i_id_rt] != '0);
  assign w_sat    = i_id_dest_en && (i_id_dest != 5'd0) &&
                    (w_cnt[i_id_dest] == CW'(MAX_INFLIGHT));
  assign w_stall  = i_id_valid && (w_raw_rs || w_raw_rt || w_sat);
  assign w_issue  = i_id_valid && !w_stall;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue && i_id_dest_en && (i_id_dest != 5'd0)) w_inc[i_id_dest] = 1'b1;
    if (i_wb_en && (i_wb_rd != 5'd0))                   w_dec[i_wb_rd]   = 1'b1;
  end

  // A retire that is not cancelled by a same-cycle issue to an idle register.
  assign w_underflow = |(w_dec & ~w_inc & ~w_pend);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
      r_opnd_valid   <= 1'b0;
      r_opnd_rs      <= 5'd0;
      r_opnd_rt      <= 5'd0;
      r_stall_cycles <= '0;
      r_wb_underflow <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        case ({w_inc[r], w_dec[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + CW'(1);
          2'b01:   if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - CW'(1);
          default: r_cnt[r] <= r_cnt[r];
        endcase
      end
      r_opnd_valid <= w_issue;
      if (w_issue) begin
        r_opnd_rs <= i_id_rs;
        r_opnd_rt <= i_id_rt;
      end
      if (w_stall && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      if (w_underflow) r_wb_underflow <= 1'b1;
    end
  end

  assign o_stall        = w_stall;
  assign o_issue        = w_issue;
  assign o_opnd_valid   = r_opnd_valid;
  assign o_opnd_rs      = r_opnd_rs;
  assign o_opnd_rt      = r_opnd_rt;
  assign o_pending_mask = {w_pend, 1'b0};
  assign o_stall_cycles = r_stall_cycles;
  assign o_wb_underflow = r_wb_underflow;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Testbench for reg_scoreboard_ctrl: directed scenarios followed by random
// traffic, all checked against a per-register outstanding-write model.
module tb_reg_scoreboard_ctrl;

  localparam int MAXF = 3;
  localparam int SCW  = 6;
  localparam int SMAX = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           reset, id_valid, id_uses_rt, id_dest_en, wb_en;
  logic [4:0]     id_rs, id_rt, id_dest, wb_rd;
  logic           stall, issue, opnd_valid, wb_underflow;
  logic [4:0]     opnd_rs, opnd_rt;
  logic [31:0]    pending_mask;
  logic [SCW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_cnt [32];
  int          m_sc;
  logic        m_ov, m_uf;
  logic [4:0]  m_ors, m_ort;

  reg_scoreboard_ctrl #(.MAX_INFLIGHT(MAXF), .STALL_CNT_W(SCW)) dut (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs(id_rs),
    .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt), .i_id_dest_en(id_dest_en),
    .i_id_dest(id_dest), .i_wb_en(wb_en), .i_wb_rd(wb_rd),
    .o_stall(stall), .o_issue(issue), .o_opnd_valid(opnd_valid),
    .o_opnd_rs(opnd_rs), .o_opnd_rt(opnd_rt), .o_pending_mask(pending_mask),
    .o_stall_cycles(stall_cycles), .o_wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the
  // model at posedge, then check registered outputs.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic de, input logic [4:0] dst,
                      input logic we, input logic [4:0] wr, input logic rst);
    logic e_stall, e_issue;
    @(negedge clk);
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur;
    id_dest_en = de; id_dest = dst; wb_en = we; wb_rd = wr;
    #1;
    e_stall = v && ((m_cnt[rs] != 0) || (ur && m_cnt[rt] != 0) ||
                    (de && dst != 0 && m_cnt[dst] == MAXF));
    e_issue = v && !e_stall;
    if (!rst) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("issue", 32'(issue), 32'(e_issue));
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_sc = 0; m_ov = 0; m_uf = 0; m_ors = 0; m_ort = 0;
    end else begin
      if (e_stall && m_sc < SMAX) m_sc++;
      m_ov = e_issue;
      if (e_issue) begin m_ors = rs; m_ort = rt; end
      if (!(e_issue && de && we && dst == wr)) begin
        if (e_issue && de && dst != 0) m_cnt[dst]++;
        if (we && wr != 0) begin
          if (m_cnt[wr] == 0) m_uf = 1'b1;
          else m_cnt[wr]--;
        end
      end
    end
    #1;
    chk("opnd_valid", 32'(opnd_valid), 32'(m_ov));
    chk("opnd_rs", 32'(opnd_rs), 32'(m_ors));
    chk("opnd_rt", 32'(opnd_rt), 32'(m_ort));
    chk("pending_mask", pending_mask, model_mask());
    chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    chk("wb_underflow", 32'(wb_underflow), 32'(m_uf));
  endtask

  initial begin
    int q[$];
    logic v, ur, de, we;
    logic [4:0] rs, rt, dst, wr;

    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_sc = 0; m_ov = 0; m_uf = 0; m_ors = 0; m_ort = 0;

    // reset with traffic present
    step(1, 7, 7, 1, 1, 7, 1, 7, 1);
    step(1, 7, 7, 1, 1, 7, 1, 7, 1);
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_sc", 32'(stall_cycles), 32'h0);

    // issue to r7, then a RAW on r7; retire without same-cycle bypass
    step(1, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("r7_pending", 32'(pending_mask[7]), 32'h1);
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 1, 7, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_sc", 32'(stall_cycles), 32'd3);

    // simultaneous inc/dec on r3
    step(1, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 1, 3, 1, 3, 0);
    chk("incdec_r3", 32'(pending_mask[3]), 32'h1);

    // saturation on r9
    repeat (3) step(1, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 1, 9, 1, 9, 0);
    step(1, 0, 0, 0, 1, 9, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(1, 9, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0);

    // r0 destination and id_uses_rt qualification
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 0);

    // underflow on idle r12, sticky until reset
    step(0, 0, 0, 0, 0, 0, 1, 12, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("uf_sticky", 32'(wb_underflow), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // self-dependent instruction on idle r5
    step(1, 5, 0, 0, 1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 1, 5, 0, 0, 0);

    // random traffic over a small register pool to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      ur  = 1'($urandom_range(0, 1));
      de  = ($urandom_range(0, 3) != 0);
      dst = 5'($urandom_range(0, 7));
      q.delete();
      for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) q.push_back(i);
      if (q.size() != 0 && $urandom_range(0, 9) < 6) begin
        we = 1'b1;
        wr = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else begin
        we = ($urandom_range(0, 15) == 0);
        wr = 5'($urandom_range(0, 15));
      end
      step(v, rs, rt, ur, de, dst, we, wr, ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard_ctrl.md
Name: reg_scoreboard_ctrl

Overview:
Issue controller sitting between the ID-stage decoder and the register file in the 5-stage pipeline.
- Tracks outstanding writes per architectural register with small counters.
- Stalls ID on RAW hazards and on counter saturation.
- Sequences the register file's 1-cycle synchronous read, raising opnd_valid when reg1/reg2 data is valid.
- Clears pending state on writeback.

Parameters:
MAX_INFLIGHT, 3, maximum outstanding writes tracked per register; counter width CW = $clog2(MAX_INFLIGHT+1)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  pipeline clock, all state on posedge
reset  input  1  synchronous, active-high; clears all state
id_valid  input  1  ID holds a decoded instruction
id_rs  input  5  source register 1
id_rt  input  5  source register 2
id_uses_rt  input  1  rt is a true source (R-type/store); 0 = rt is destination or unused
id_dest_en  input  1  instruction writes a register
id_dest  input  5  destination register (rd or rt per format)
wb_en  input  1  writeback retires one write this cycle
wb_rd  input  5  register retired
stall  output  1  combinational; hold IF/ID this cycle
issue  output  1  combinational; id_valid && !stall
opnd_valid  output  1  registered; regfile read data valid this cycle
opnd_rs  output  5  registered rs of the issued instruction
opnd_rt  output  5  registered rt of the issued instruction
pending_mask  output  32  bit i = (cnt[i] != 0); bit 0 always 0
stall_cycles  output  STALL_CNT_W  saturating count of cycles with stall=1
wb_underflow  output  1  sticky error flag

Behaviour:
- State: cnt[1..31], each CW bits. cnt[0] does not exist and reads as 0.
- Reset (sync, high): all cnt=0, opnd_valid=0, opnd_rs=0, opnd_rt=0, stall_cycles=0, wb_underflow=0. pending_mask=0 and stall=0 follow combinationally. Reset overrides every other event in the same cycle, including an in-flight opnd_valid.
- Hazard terms, all combinational and evaluated with current-cycle inputs and current cnt:
  - raw_rs = cnt[id_rs] != 0
  - raw_rt = id_uses_rt && cnt[id_rt] != 0
  - sat = id_dest_en && id_dest != 0 && cnt[id_dest] == MAX_INFLIGHT
- stall = id_valid && (raw_rs || raw_rt || sat). stall is 0 when id_valid=0.
- No same-cycle bypass: a wb_en to a source register does not suppress stall that cycle. The instruction issues the next cycle if the count has reached 0.
- Register 0 never causes a hazard and is never counted. id_dest=0 and wb_rd=0 are ignored.
- Counter update per register r, at each posedge:
  - inc = issue && id_dest_en && id_dest == r
  - dec = wb_en && wb_rd == r
  - inc only: cnt+1. dec only: cnt-1. inc and dec together: cnt unchanged.
- Underflow: dec only with cnt[r]==0 leaves cnt at 0 and sets wb_underflow=1. The flag holds until reset.
- Overflow cannot occur, because sat blocks issue.
- Read sequencing, 1-cycle latency matching the synchronous regfile:
  - On an issue cycle, the next cycle has opnd_valid=1, opnd_rs=id_rs, opnd_rt=id_rt.
  - Otherwise opnd_valid=0 and opnd_rs/opnd_rt hold their last values.
  - Back-to-back issues give opnd_valid high on consecutive cycles.
- stall_cycles increments each cycle stall=1 and saturates at all-ones. It never wraps.
- A self-dependent instruction checks sources against pre-issue counts. Example: rs=dest=5 with cnt[5]=0 issues, then cnt[5] becomes 1.

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1 and wb_en=1 -> pending_mask=0, stall=0, opnd_valid=0, stall_cycles=0 after release.
- Issue then RAW:
  - Cycle 0: id_dest_en=1, id_dest=7, issues.
  - Cycle 1: opnd_valid=1, cnt[7]=1; next instr rs=7 -> stall=1 until the cycle after wb_en with wb_rd=7, then issue=1.
  - stall_cycles equals the number of stalled cycles.
- Simultaneous inc/dec: cnt[3]=1, same cycle issue dest=3 and wb_en wb_rd=3 -> cnt[3] stays 1, pending_mask[3]=1.
- Saturation, MAX_INFLIGHT=3: three issues to dest=9 -> fourth stalls (sat). One wb to 9 -> fourth issues next cycle, cnt[9]=3.
- R0 and id_uses_rt:
  - dest=0 issues -> pending_mask stays 0.
  - With cnt[4]=1, instr id_rt=4, id_uses_rt=0 -> no stall. Same with id_uses_rt=1 -> stall.
- Underflow: wb_en wb_rd=12 with cnt[12]=0 -> wb_underflow=1, cnt stays 0, flag held until reset.
